// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the hart-tagged immediate generator: selector encoding,
// the S1 beat record and pipeline constants.
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_U  = 3'd3,
    IMM_J  = 3'd4,
    IMM_Z  = 3'd5,
    IMM_SH = 3'd6
  } imm_sel_e;

  localparam int IMM_LAT       = 2;
  localparam int IMM_NUM_HARTS = 8;
  localparam int IMM_HART_W    = $clog2(IMM_NUM_HARTS);

  typedef struct packed {
    logic [31:0]           instr;
    imm_sel_e              sel;
    logic [IMM_HART_W-1:0] hart;
  } imm_beat_t;

  function automatic logic sel_legal(imm_sel_e sel);
    return sel inside {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH};
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Input and output valid/ready channels of the immediate generator.
// master = beat producer / result consumer, slave = the generator.
interface imm_gen_pipe_if #(
  parameter int XLEN      = 32,
  parameter int NUM_HARTS = 8
);
  localparam int HART_W = $clog2(NUM_HARTS);

  logic                           in_valid;
  logic                           in_ready;
  logic [31:0]                    in_instr;
  imm_gen_pipe_pkg::imm_sel_e     in_sel;
  logic [HART_W-1:0]              in_hart;

  logic                           out_valid;
  logic                           out_ready;
  logic [XLEN-1:0]                out_imm;
  logic [HART_W-1:0]              out_hart;
  logic                           out_err;

  modport master (
    output in_valid, in_instr, in_sel, in_hart, out_ready,
    input  in_ready, out_valid, out_imm, out_hart, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_sel, in_hart, out_ready,
    output in_ready, out_valid, out_imm, out_hart, out_err
  );

endinterface

// File: rtl/imm_gen_pipe_xlen.sv
// Combinational RISC-V immediate decode for one instruction word.
// Unknown selectors decode as I-format and raise err.
module imm_gen_xlen
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_sel_e        sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves it unassigned (no latch).
    imm       = {XLEN{instr[31]}};
    imm[11:0] = instr[31:20];
    err       = 1'b0;
    case (sel)
      IMM_I: begin
      end
      IMM_S: imm[11:0] = {instr[31:25], instr[11:7]};
      IMM_B: imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: imm[31:0] = {instr[31:12], 12'b0};
      IMM_Z: begin
        imm      = '0;
        imm[4:0] = instr[19:15];
      end
      IMM_SH: begin
        imm = '0;
        if (XLEN == 64) imm[5:0] = instr[25:20];
        else            imm[4:0] = instr[24:20];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage elastic pipeline around imm_gen_xlen with per-hart flush and a
// saturating count of illegal-selector beats.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_HARTS = IMM_NUM_HARTS,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_gen_pipe_if.slave        bus,
  input  logic [NUM_HARTS-1:0] flush_mask,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int HART_W = $clog2(NUM_HARTS);

  logic              s1_valid;
  imm_beat_t         s1_beat;
  logic [HART_W-1:0] s1_hart;
  logic              s2_valid;
  logic [XLEN-1:0]   s2_imm;
  logic [HART_W-1:0] s2_hart;
  logic              s2_err;

  logic              s1_adv;
  logic              s2_adv;
  logic              s1_flush;
  logic              s2_flush;
  logic              in_flush;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_err;

  imm_gen_xlen #(.XLEN(XLEN)) u_dec (
    .instr (s1_beat.instr),
    .sel   (s1_beat.sel),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  assign s1_hart  = HART_W'(s1_beat.hart);
  assign s1_flush = s1_valid & flush_mask[s1_hart];
  assign s2_flush = s2_valid & flush_mask[s2_hart];
  assign in_flush = flush_mask[bus.in_hart];

  // NOTE: in_ready is combinational from out_ready so a full pipe still streams at one beat per cycle.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  // A beat being flushed this cycle is hidden so the consumer never takes it.
  assign bus.out_valid = s2_valid & ~s2_flush;
  assign bus.out_imm   = s2_imm;
  assign bus.out_hart  = s2_hart;
  assign bus.out_err   = s2_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_imm    <= '0;
      s2_hart   <= '0;
      s2_err    <= 1'b0;
      err_count <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid & ~s1_flush;
        if (s1_valid) begin
          s2_imm  <= dec_imm;
          s2_hart <= s1_hart;
          s2_err  <= dec_err;
        end
      end else if (s2_flush) begin
        s2_valid <= 1'b0;
      end

      if (s1_adv) begin
        s1_valid <= bus.in_valid & ~in_flush;
      end else if (s1_flush) begin
        s1_valid <= 1'b0;
      end

      // Flushed beats are still accepted, so they still count.
      if (bus.in_valid && s1_adv && !sel_legal(bus.in_sel) && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

  // NOTE: the S1 payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      s1_beat.instr <= bus.in_instr;
      s1_beat.sel   <= bus.in_sel;
      s1_beat.hart  <= IMM_HART_W'(bus.in_hart);
    end
  end

endmodule
